// File: rtl/inv_rotate_unit_pkg.sv
// -----------------------------------------------------------------------------
// inv_rotate_unit_pkg
//   Shared definitions for the inverse rho (lane rotate) unit:
//     - state geometry (SLICE_W lanes per slice, LANE_LEN slices per state)
//     - Keccak rho offset table, indexed by lane i = 5*y + x
//     - FSM state encoding shared by the controller
//     - rho_src(): slice index holding the bit that un-rotates into slice z
// -----------------------------------------------------------------------------
package inv_rotate_unit_pkg;

  localparam int unsigned SLICE_W  = 25;
  localparam int unsigned LANE_LEN = 64;
  localparam int unsigned Z_W      = 6;

  typedef logic [Z_W-1:0]     z_idx_t;
  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  localparam z_idx_t Z_ONE = z_idx_t'(1);
  localparam z_idx_t Z_MAX = z_idx_t'(LANE_LEN - 1);

  // Rho offsets, i = 5*y + x.
  localparam z_idx_t RHO_OFFS [0:SLICE_W-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,   // y = 0, x = 0..4
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,   // y = 1
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,   // y = 2
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,    // y = 3
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14    // y = 4
  };

  // The encoder moved bit z of lane i to z + r_i; undoing it reads z + r_i.
  // 6-bit arithmetic gives the mod-64 wrap for free.
  function automatic z_idx_t rho_src(input z_idx_t z, input int unsigned lane);
    return z + RHO_OFFS[lane];
  endfunction

endpackage

// File: rtl/inv_rotate_unit_ctrl.sv
// -----------------------------------------------------------------------------
// inv_rotate_unit_ctrl
//   Load/emit sequencer for inv_rotate_unit. Counts slices in during S_LOAD,
//   counts slices out during S_EMIT, and flags the last slice and the end of
//   each state.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous reset, active low
//   in_valid_i   upstream slice valid
//   out_ready_i  downstream ready
//   in_ready_o   slice accepted this cycle when in_valid_i is high (registered)
//   out_valid_o  output slice valid (registered)
//   out_last_o   high while slice z = 63 is presented
//   done_o       one-cycle pulse after the final output handshake (registered)
//   z_in_o       write index into the slice buffer
//   z_out_o      read base index for the un-rotate muxes
// -----------------------------------------------------------------------------
module inv_rotate_unit_ctrl
  import inv_rotate_unit_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   in_valid_i,
  input  logic   out_ready_i,
  output logic   in_ready_o,
  output logic   out_valid_o,
  output logic   out_last_o,
  output logic   done_o,
  output z_idx_t z_in_o,
  output z_idx_t z_out_o
);

  state_e state_q;
  z_idx_t z_in_q;
  z_idx_t z_out_q;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   done_q;

  // in_ready_q resets low and is raised by the first edge after release,
  // so nothing is accepted while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_LOAD;
      z_in_q      <= '0;
      z_out_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            z_in_q <= z_in_q + Z_ONE;
            if (z_in_q == Z_MAX) begin
              state_q     <= S_EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_valid_q && out_ready_i) begin
            z_out_q <= z_out_q + Z_ONE;
            if (z_out_q == Z_MAX) begin
              state_q     <= S_LOAD;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              done_q      <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_valid_q && (z_out_q == Z_MAX);
  assign done_o      = done_q;
  assign z_in_o      = z_in_q;
  assign z_out_o     = z_out_q;

endmodule

// File: rtl/inv_rotate_unit.sv
// -----------------------------------------------------------------------------
// inv_rotate_unit
//   Inverse of the rho lane-rotate step of the 5x5x64 state encoder. Buffers a
//   full state delivered as 64 slices (z = 0..63), then streams 64 slices with
//   every lane rotated back by its rho offset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low; clears state, counters, buffer
//   in_valid   in_slice valid
//   in_ready   slice accepted this cycle (only while loading)
//   in_slice   input slice, bit i = lane (x,y), i = 5*y + x
//   out_valid  out_slice valid (only while emitting)
//   out_ready  consumer accepts out_slice
//   out_slice  un-rotated slice, same bit mapping
//   out_last   high with slice z = 63
//   done       one-cycle pulse after the last output handshake
// -----------------------------------------------------------------------------
module inv_rotate_unit
  import inv_rotate_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic               out_last,
  output logic               done
);

  slice_t mem_q [LANE_LEN];
  z_idx_t z_in;
  z_idx_t z_out;
  logic   wr_en;

  inv_rotate_unit_ctrl u_ctrl (
    .clk_i       (clk),
    .rst_ni      (rst),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .done_o      (done),
    .z_in_o      (z_in),
    .z_out_o     (z_out)
  );

  assign wr_en = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned z = 0; z < LANE_LEN; z++) begin
        mem_q[z] <= '0;
      end
    end else if (wr_en) begin
      mem_q[z_in] <= in_slice;
    end
  end

  // Each lane has its own read mux: the slice it reads from is offset by that
  // lane's rho constant. Purely combinational, so the slice holds under stall.
  // The buffer is zeroed by reset, which also keeps out_slice at 0 during it.
  for (genvar i = 0; i < SLICE_W; i++) begin : g_lane
    z_idx_t rd_z;
    assign rd_z         = rho_src(z_out, i);
    assign out_slice[i] = mem_q[rd_z][i];
  end

endmodule

// File: tb/tb_inv_rotate_unit.sv
module tb_inv_rotate_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;
  logic        out_last;
  logic        done;

  inv_rotate_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Rho offsets as rows over x, each row listing y = 0..4.
  int rho_xy [5][5] = '{'{0, 36, 3, 41, 18},
                        '{1, 44, 10, 45, 2},
                        '{62, 6, 43, 15, 61},
                        '{28, 55, 25, 21, 56},
                        '{27, 20, 39, 8, 14}};

  logic [24:0] src [64];
  logic [24:0] in_q [$];
  logic [24:0] exp_out [$];
  logic [24:0] got [$];
  logic        got_last [$];
  int          in_cyc [$];
  int          out_cyc [$];
  logic [26:0] stall_a [$];
  logic [26:0] stall_b [$];
  int          cyc = 0;
  int          dones = 0;
  int          extra_valid = 0;

  function automatic int rho_of(input int i);
    return rho_xy[i % 5][i / 5];
  endfunction

  task automatic clear_bufs();
    in_q.delete(); exp_out.delete(); got.delete(); got_last.delete();
    in_cyc.delete(); out_cyc.delete(); stall_a.delete(); stall_b.delete();
    dones = 0; extra_valid = 0;
  endtask

  task automatic random_src();
    for (int z = 0; z < 64; z++) src[z] = 25'($urandom);
  endtask

  // Feed src unchanged; expected output is each lane rotated right by r.
  task automatic push_plain();
    logic [63:0] lane;
    logic [24:0] o [64];
    int r;
    for (int z = 0; z < 64; z++) begin in_q.push_back(src[z]); o[z] = '0; end
    for (int i = 0; i < 25; i++) begin
      r = rho_of(i);
      for (int z = 0; z < 64; z++) lane[z] = src[z][i];
      lane = (lane >> r) | (lane << (64 - r));
      for (int z = 0; z < 64; z++) o[z][i] = lane[z];
    end
    for (int z = 0; z < 64; z++) exp_out.push_back(o[z]);
  endtask

  // Encoder rho (rotate left by r) applied to src, fed in; expect src back.
  task automatic push_encoded();
    logic [63:0] lane;
    logic [24:0] e [64];
    int r;
    for (int z = 0; z < 64; z++) e[z] = '0;
    for (int i = 0; i < 25; i++) begin
      r = rho_of(i);
      for (int z = 0; z < 64; z++) lane[z] = src[z][i];
      lane = (lane << r) | (lane >> (64 - r));
      for (int z = 0; z < 64; z++) e[z][i] = lane[z];
    end
    for (int z = 0; z < 64; z++) begin in_q.push_back(e[z]); exp_out.push_back(src[z]); end
  endtask

  // Drive/observe at negedges; handshakes happen at the following posedge.
  task automatic run(input int n_out, input bit bp, input int budget, output bit tmo);
    bit          prev_stall;
    logic [26:0] prev_obs;
    prev_stall = 1'b0;
    prev_obs   = '0;
    for (int k = 0; k < budget && got.size() < n_out; k++) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (prev_stall) begin
        stall_a.push_back(prev_obs);
        stall_b.push_back({out_valid, out_last, out_slice});
      end
      out_ready = bp ? ((cyc % 2) == 0) : 1'b1;
      if (out_valid && out_ready) begin
        got.push_back(out_slice);
        got_last.push_back(out_last);
        out_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = {out_valid, out_last, out_slice};
      if (in_q.size() > 0) begin
        in_valid = 1'b1;
        in_slice = in_q[0];
        if (in_ready) begin
          void'(in_q.pop_front());
          in_cyc.push_back(cyc);
        end
      end else begin
        // Junk offered only while emitting: must be ignored.
        in_valid = out_valid;
        in_slice = 25'($urandom);
      end
    end
    tmo = (got.size() < n_out);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (done) dones++;
      if (out_valid) extra_valid++;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_slice = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (out_slice !== 25'h0) begin errors++; $display("FAIL rst_out_slice got %h want 0", out_slice); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_directed(input string name, input int zi, input logic [24:0] v, input int zexp);
    bit tmo;
    logic [24:0] want;
    clear_bufs();
    for (int z = 0; z < 64; z++) src[z] = '0;
    src[zi] = v;
    push_plain();
    run(64, 1'b0, 400, tmo);
    drain(3);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout got %0d slices want 64", name, got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      want = (k == zexp) ? v : 25'h0;
      checks++; if (got[k] !== want) begin errors++; $display("FAIL %s_lit z=%0d got %h want %h", name, k, got[k], want); end
      checks++; if (got[k] !== exp_out[k]) begin errors++; $display("FAIL %s_model z=%0d got %h want %h", name, k, got[k], exp_out[k]); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL %s_last z=%0d got %b want %b", name, k, got_last[k], (k == 63)); end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL %s_done got %0d pulses want 1", name, dones); end
    checks++; if (extra_valid !== 0) begin errors++; $display("FAIL %s_extra got %0d want 0", name, extra_valid); end
  endtask

  task automatic test_backpressure();
    bit tmo;
    clear_bufs();
    random_src();
    push_plain();
    run(64, 1'b1, 600, tmo);
    drain(3);
    checks++; if (tmo) begin errors++; $display("FAIL bp_timeout got %0d slices want 64", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== exp_out[k]) begin errors++; $display("FAIL bp_data z=%0d got %h want %h", k, got[k], exp_out[k]); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL bp_last z=%0d got %b want %b", k, got_last[k], (k == 63)); end
    end
    checks++; if (stall_a.size() < 32) begin errors++; $display("FAIL bp_stalls got %0d want >=32", stall_a.size()); end
    for (int k = 0; k < stall_a.size(); k++) begin
      checks++; if (stall_b[k] !== stall_a[k]) begin errors++; $display("FAIL bp_hold n=%0d got %h want %h", k, stall_b[k], stall_a[k]); end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL bp_done got %0d pulses want 1", dones); end
    checks++; if (extra_valid !== 0) begin errors++; $display("FAIL bp_extra got %0d want 0", extra_valid); end
  endtask

  task automatic test_back_to_back();
    bit tmo;
    clear_bufs();
    random_src(); push_encoded();
    random_src(); push_encoded();
    run(128, 1'b0, 800, tmo);
    drain(3);
    checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout got %0d slices want 128", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== exp_out[k]) begin errors++; $display("FAIL b2b_data n=%0d got %h want %h", k, got[k], exp_out[k]); end
      checks++; if (got_last[k] !== ((k % 64) == 63)) begin errors++; $display("FAIL b2b_last n=%0d got %b want %b", k, got_last[k], ((k % 64) == 63)); end
    end
    if (in_cyc.size() == 128 && out_cyc.size() == 128) begin
      checks++; if (in_cyc[63] - in_cyc[0] !== 63) begin errors++; $display("FAIL b2b_load_span got %0d want 63", in_cyc[63] - in_cyc[0]); end
      checks++; if (out_cyc[0] - in_cyc[63] !== 1) begin errors++; $display("FAIL b2b_out_lat got %0d want 1", out_cyc[0] - in_cyc[63]); end
      checks++; if (in_cyc[64] - in_cyc[0] !== 128) begin errors++; $display("FAIL b2b_period got %0d want 128", in_cyc[64] - in_cyc[0]); end
      checks++; if (in_cyc[64] - out_cyc[63] !== 1) begin errors++; $display("FAIL b2b_in_lat got %0d want 1", in_cyc[64] - out_cyc[63]); end
    end else begin
      checks++; errors++;
      $display("FAIL b2b_counts got in=%0d out=%0d want 128/128", in_cyc.size(), out_cyc.size());
    end
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done got %0d pulses want 2", dones); end
  endtask

  task automatic test_reset_mid_emit();
    bit tmo;
    clear_bufs();
    random_src();
    push_encoded();
    run(30, 1'b0, 400, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rme_timeout got %0d slices want 30", got.size()); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rme_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rme_out_valid got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rme_out_last got %b want 0", out_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rme_done got %b want 0", done); end
    checks++; if (out_slice !== 25'h0) begin errors++; $display("FAIL rme_out_slice got %h want 0", out_slice); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rme_early_done got %0d want 0", dones); end
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rme_rel_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rme_rel_out_valid got %b want 0", out_valid); end
    clear_bufs();
    random_src();
    push_encoded();
    run(64, 1'b0, 400, tmo);
    drain(3);
    checks++; if (tmo) begin errors++; $display("FAIL rme_fresh_timeout got %0d slices want 64", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++; if (got[k] !== exp_out[k]) begin errors++; $display("FAIL rme_fresh z=%0d got %h want %h", k, got[k], exp_out[k]); end
      checks++; if (got_last[k] !== (k == 63)) begin errors++; $display("FAIL rme_last z=%0d got %b want %b", k, got_last[k], (k == 63)); end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL rme_done_cnt got %0d pulses want 1", dones); end
  endtask

  initial begin
    test_reset();
    test_directed("passthrough", 5, 25'h0000001, 5);
    test_directed("offset1", 1, 25'h0000002, 0);
    test_directed("wrap", 0, 25'h0000004, 2);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
